// File: rtl/spu_writeback_forward_pipe.sv
// Dual-pipe result delay line with operand forwarding; the SPU_FWD_EN macro builds the forwarding comparators.
// Latency DEPTH cycles EX-to-writeback (+1 per stall cycle); stall freezes all stages, flush kills all but the oldest stage.
module spu_writeback_forward_pipe #(
  parameter int DEPTH = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         resValid_EX1,
  input  logic         resValid_EX2,
  input  logic [6:0]   resRT_EX1,
  input  logic [6:0]   resRT_EX2,
  input  logic [127:0] resData_EX1,
  input  logic [127:0] resData_EX2,
  input  logic         stall,
  input  logic         flush,
  input  logic [6:0]   readRegisterRA_REG1,
  input  logic [6:0]   readRegisterRA_REG2,
  input  logic [6:0]   readRegisterRB_REG1,
  input  logic [6:0]   readRegisterRB_REG2,
  input  logic [6:0]   readRegisterRC_REG1,
  input  logic [6:0]   readRegisterRC_REG2,
  output logic [5:0]   fwdHit,
  output logic [127:0] fwdData0,
  output logic [127:0] fwdData1,
  output logic [127:0] fwdData2,
  output logic [127:0] fwdData3,
  output logic [127:0] fwdData4,
  output logic [127:0] fwdData5,
  output logic [6:0]   readRegisterRT_WB1,
  output logic [6:0]   readRegisterRT_WB2,
  output logic [127:0] writeData_WB1,
  output logic [127:0] writeData_WB2,
  output logic         regWriteEnable_WB1,
  output logic         regWriteEnable_WB2,
  output logic [4:0]   inFlight
);

  typedef struct packed {
    logic         vld;
    logic [6:0]   rt;
    logic [127:0] dat;
  } entry_t;

  entry_t [DEPTH-1:0] p1_q, p2_q, p1_d, p2_d;
  logic [4:0]         cnt_d;
  logic               adv;
  logic               wb_hold;
  entry_t             wb1, wb2;
  logic [5:0]         fwd_hit;
  logic [5:0][127:0]  fwd_dat;

  // Flush must advance even under stall so the oldest entry still retires.
  assign adv     = flush | ~stall;
  assign wb_hold = stall & ~flush;

  always_comb begin
    p1_d    = p1_q;
    p2_d    = p2_q;
    p1_d[0] = {resValid_EX1, resRT_EX1, resData_EX1};
    p2_d[0] = {resValid_EX2, resRT_EX2, resData_EX2};
    for (int k = 1; k < DEPTH; k++) begin
      p1_d[k] = p1_q[k-1];
      p2_d[k] = p2_q[k-1];
    end
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        p1_d[k].vld = 1'b0;
        p2_d[k].vld = 1'b0;
      end
    end
    cnt_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_d = cnt_d + {4'b0, p1_d[k].vld} + {4'b0, p2_d[k].vld};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_q     <= '0;
      p2_q     <= '0;
      inFlight <= '0;
    end else if (adv) begin
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      inFlight <= cnt_d;
    end
  end

  assign wb1 = p1_q[DEPTH-1];
  assign wb2 = p2_q[DEPTH-1];

  // Pipe 2 is later in program order, so it alone commits a shared destination.
  assign regWriteEnable_WB1 = wb1.vld & ~wb_hold & ~(wb2.vld & (wb2.rt == wb1.rt));
  assign regWriteEnable_WB2 = wb2.vld & ~wb_hold;
  assign readRegisterRT_WB1 = wb1.rt;
  assign readRegisterRT_WB2 = wb2.rt;
  assign writeData_WB1      = wb1.dat;
  assign writeData_WB2      = wb2.dat;

`ifdef SPU_FWD_EN
  logic [5:0][6:0] rd_addr;
  assign rd_addr = {readRegisterRC_REG2, readRegisterRC_REG1, readRegisterRB_REG2,
                    readRegisterRB_REG1, readRegisterRA_REG2, readRegisterRA_REG1};

  // Scan oldest to youngest so the last assignment is the youngest match.
  always_comb begin
    fwd_hit = '0;
    fwd_dat = '0;
    for (int i = 0; i < 6; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (p1_q[k].vld && (p1_q[k].rt == rd_addr[i])) begin
          fwd_hit[i] = 1'b1;
          fwd_dat[i] = p1_q[k].dat;
        end
        if (p2_q[k].vld && (p2_q[k].rt == rd_addr[i])) begin
          fwd_hit[i] = 1'b1;
          fwd_dat[i] = p2_q[k].dat;
        end
      end
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{readRegisterRA_REG1, readRegisterRA_REG2, readRegisterRB_REG1,
                            readRegisterRB_REG2, readRegisterRC_REG1, readRegisterRC_REG2};
  assign fwd_hit = '0;
  assign fwd_dat = '0;
`endif

  assign fwdHit   = fwd_hit;
  assign fwdData0 = fwd_dat[0];
  assign fwdData1 = fwd_dat[1];
  assign fwdData2 = fwd_dat[2];
  assign fwdData3 = fwd_dat[3];
  assign fwdData4 = fwd_dat[4];
  assign fwdData5 = fwd_dat[5];

endmodule

// File: tb/tb_spu_writeback_forward_pipe.sv
// Directed bench for spu_writeback_forward_pipe at DEPTH=6: writeback timing, forwarding priority,
// same-destination suppression, stall, flush and mid-run reset.
module tb_spu_writeback_forward_pipe;
  localparam int DEPTH = 6;
`ifdef SPU_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic         clk;
  logic         reset_n;
  logic         resValid_EX1, resValid_EX2;
  logic [6:0]   resRT_EX1, resRT_EX2;
  logic [127:0] resData_EX1, resData_EX2;
  logic         stall, flush;
  logic [6:0]   readRegisterRA_REG1, readRegisterRA_REG2;
  logic [6:0]   readRegisterRB_REG1, readRegisterRB_REG2;
  logic [6:0]   readRegisterRC_REG1, readRegisterRC_REG2;
  logic [5:0]   fwdHit;
  logic [127:0] fwdData0, fwdData1, fwdData2, fwdData3, fwdData4, fwdData5;
  logic [6:0]   readRegisterRT_WB1, readRegisterRT_WB2;
  logic [127:0] writeData_WB1, writeData_WB2;
  logic         regWriteEnable_WB1, regWriteEnable_WB2;
  logic [4:0]   inFlight;

  int checks = 0;
  int errors = 0;

  spu_writeback_forward_pipe #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .resValid_EX1(resValid_EX1), .resValid_EX2(resValid_EX2),
    .resRT_EX1(resRT_EX1), .resRT_EX2(resRT_EX2),
    .resData_EX1(resData_EX1), .resData_EX2(resData_EX2),
    .stall(stall), .flush(flush),
    .readRegisterRA_REG1(readRegisterRA_REG1), .readRegisterRA_REG2(readRegisterRA_REG2),
    .readRegisterRB_REG1(readRegisterRB_REG1), .readRegisterRB_REG2(readRegisterRB_REG2),
    .readRegisterRC_REG1(readRegisterRC_REG1), .readRegisterRC_REG2(readRegisterRC_REG2),
    .fwdHit(fwdHit),
    .fwdData0(fwdData0), .fwdData1(fwdData1), .fwdData2(fwdData2),
    .fwdData3(fwdData3), .fwdData4(fwdData4), .fwdData5(fwdData5),
    .readRegisterRT_WB1(readRegisterRT_WB1), .readRegisterRT_WB2(readRegisterRT_WB2),
    .writeData_WB1(writeData_WB1), .writeData_WB2(writeData_WB2),
    .regWriteEnable_WB1(regWriteEnable_WB1), .regWriteEnable_WB2(regWriteEnable_WB2),
    .inFlight(inFlight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Forwarded values only appear when the forwarding network is built.
  function automatic logic [127:0] fx(input logic [127:0] v);
    return FWD_ON ? v : 128'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    resValid_EX1 = 1'b0; resValid_EX2 = 1'b0;
    resRT_EX1 = '0; resRT_EX2 = '0;
    resData_EX1 = '0; resData_EX2 = '0;
    stall = 1'b0; flush = 1'b0;
    readRegisterRA_REG1 = 7'd0;   readRegisterRA_REG2 = 7'd127;
    readRegisterRB_REG1 = 7'd127; readRegisterRB_REG2 = 7'd127;
    readRegisterRC_REG1 = 7'd127; readRegisterRC_REG2 = 7'd127;

    // Reset state; register 0 must not hit on invalid reset entries.
    #12;
    check("rst_we", {regWriteEnable_WB1, regWriteEnable_WB2}, 2'b00);
    check("rst_inflight", inFlight, 5'd0);
    check("rst_fwdhit", fwdHit, 6'd0);
    check("rst_wbdata", writeData_WB1 | writeData_WB2, 128'h0);
    reset_n = 1'b1;
    tick();

    // Single result on pipe 1 retires after DEPTH cycles.
    readRegisterRA_REG1 = 7'd5;
    resValid_EX1 = 1'b1; resRT_EX1 = 7'd5; resData_EX1 = 128'h1234;
    tick();
    resValid_EX1 = 1'b0;
    check("s1_fwdhit", fwdHit, fx(6'b000001));
    check("s1_fwddata", fwdData0, fx(128'h1234));
    for (int i = 0; i < DEPTH - 1; i++) begin
      check("s1_we_early", regWriteEnable_WB1, 1'b0);
      check("s1_inflight", inFlight, 5'd1);
      tick();
    end
    check("s1_we", regWriteEnable_WB1, 1'b1);
    check("s1_rt", readRegisterRT_WB1, 7'd5);
    check("s1_data", writeData_WB1, 128'h1234);
    check("s1_we2", regWriteEnable_WB2, 1'b0);
    check("s1_inflight_wb", inFlight, 5'd1);
    tick();
    check("s1_we_after", regWriteEnable_WB1, 1'b0);
    check("s1_inflight_after", inFlight, 5'd0);

    // Youngest match wins; live EX inputs are not forwarded.
    readRegisterRA_REG1 = 7'd10;
    resValid_EX1 = 1'b1; resRT_EX1 = 7'd10; resData_EX1 = 128'hAAAA;
    tick();
    resData_EX1 = 128'hBBBB;
    #1;
    check("s2_hit_a", fwdHit, fx(6'b000001));
    check("s2_data_a", fwdData0, fx(128'hAAAA));
    tick();
    resValid_EX1 = 1'b0;
    check("s2_data_b", fwdData0, fx(128'hBBBB));
    tick();
    check("s2_data_b2", fwdData0, fx(128'hBBBB));
    check("s2_inflight", inFlight, 5'd2);
    repeat (5) tick();
    check("s2_drained", inFlight, 5'd0);
    check("s2_nohit", fwdHit, 6'd0);

    // Same destination on both pipes: pipe 2 wins forwarding and writeback.
    readRegisterRA_REG1 = 7'd7; readRegisterRC_REG2 = 7'd7;
    resValid_EX1 = 1'b1; resRT_EX1 = 7'd7; resData_EX1 = 128'h11;
    resValid_EX2 = 1'b1; resRT_EX2 = 7'd7; resData_EX2 = 128'h22;
    tick();
    resValid_EX1 = 1'b0; resValid_EX2 = 1'b0;
    check("s3_hit", fwdHit, fx(6'b100001));
    check("s3_data0", fwdData0, fx(128'h22));
    check("s3_data5", fwdData5, fx(128'h22));
    repeat (DEPTH - 1) tick();
    check("s3_we1", regWriteEnable_WB1, 1'b0);
    check("s3_we2", regWriteEnable_WB2, 1'b1);
    check("s3_rt2", readRegisterRT_WB2, 7'd7);
    check("s3_data2", writeData_WB2, 128'h22);
    tick();
    check("s3_we2_after", regWriteEnable_WB2, 1'b0);
    check("s3_inflight", inFlight, 5'd0);
    readRegisterRA_REG1 = 7'd127; readRegisterRC_REG2 = 7'd127;

    // Two stall cycles with the entry in stage 3; held EX input is ignored.
    readRegisterRA_REG2 = 7'd20;
    resValid_EX2 = 1'b1; resRT_EX2 = 7'd20; resData_EX2 = 128'h55;
    tick();
    resValid_EX2 = 1'b0;
    repeat (3) tick();
    stall = 1'b1;
    resValid_EX1 = 1'b1; resRT_EX1 = 7'd30; resData_EX1 = 128'h99;
    tick();
    check("s4_stall_we_a", regWriteEnable_WB2, 1'b0);
    check("s4_stall_inflight", inFlight, 5'd1);
    check("s4_stall_fwd", fwdHit, fx(6'b000010));
    tick();
    check("s4_stall_we_b", regWriteEnable_WB2, 1'b0);
    resValid_EX1 = 1'b0;
    stall = 1'b0;
    tick();
    check("s4_we_delayed", regWriteEnable_WB2, 1'b0);
    tick();
    check("s4_we", regWriteEnable_WB2, 1'b1);
    check("s4_data", writeData_WB2, 128'h55);
    tick();
    check("s4_we_once", regWriteEnable_WB2, 1'b0);
    check("s4_inflight", inFlight, 5'd0);
    readRegisterRA_REG2 = 7'd127;

    // Stall while the entry sits in the last stage suppresses the write until release.
    resValid_EX1 = 1'b1; resRT_EX1 = 7'd21; resData_EX1 = 128'h66;
    tick();
    resValid_EX1 = 1'b0;
    repeat (DEPTH - 1) tick();
    check("s4b_we", regWriteEnable_WB1, 1'b1);
    stall = 1'b1;
    #1;
    check("s4b_stall_we", regWriteEnable_WB1, 1'b0);
    tick();
    check("s4b_stall_we2", regWriteEnable_WB1, 1'b0);
    check("s4b_hold_data", writeData_WB1, 128'h66);
    stall = 1'b0;
    #1;
    check("s4b_we_release", regWriteEnable_WB1, 1'b1);
    tick();
    check("s4b_we_once", regWriteEnable_WB1, 1'b0);
    check("s4b_inflight", inFlight, 5'd0);

    // Flush (with stall also raised) with entries in stages 0, 2 and DEPTH-1.
    resValid_EX1 = 1'b1; resRT_EX1 = 7'd40; resData_EX1 = 128'hA0;
    tick();
    resValid_EX1 = 1'b0;
    tick();
    tick();
    resValid_EX1 = 1'b1; resRT_EX1 = 7'd41; resData_EX1 = 128'hB0;
    tick();
    resValid_EX1 = 1'b0;
    tick();
    resValid_EX1 = 1'b1; resRT_EX1 = 7'd42; resData_EX1 = 128'hC0;
    tick();
    resValid_EX1 = 1'b0;
    check("s5_inflight_pre", inFlight, 5'd3);
    flush = 1'b1; stall = 1'b1;
    resValid_EX2 = 1'b1; resRT_EX2 = 7'd43; resData_EX2 = 128'h77;
    #1;
    check("s5_we_oldest", regWriteEnable_WB1, 1'b1);
    check("s5_rt_oldest", readRegisterRT_WB1, 7'd40);
    check("s5_data_oldest", writeData_WB1, 128'hA0);
    tick();
    flush = 1'b0; stall = 1'b0; resValid_EX2 = 1'b0;
    check("s5_inflight_post", inFlight, 5'd0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      check("s5_no_wb", {regWriteEnable_WB1, regWriteEnable_WB2}, 2'b00);
      tick();
    end

    // Reset mid-run with four entries in flight.
    readRegisterRA_REG1 = 7'd50;
    resValid_EX1 = 1'b1; resRT_EX1 = 7'd50; resData_EX1 = 128'h501;
    resValid_EX2 = 1'b1; resRT_EX2 = 7'd51; resData_EX2 = 128'h511;
    tick();
    resRT_EX1 = 7'd52; resRT_EX2 = 7'd53;
    tick();
    resValid_EX1 = 1'b0; resValid_EX2 = 1'b0;
    check("s6_inflight_pre", inFlight, 5'd4);
    check("s6_hit_pre", fwdHit, fx(6'b000001));
    #2;
    reset_n = 1'b0;
    #1;
    check("s6_rst_inflight", inFlight, 5'd0);
    check("s6_rst_hit", fwdHit, 6'd0);
    check("s6_rst_fwddata", fwdData0, 128'h0);
    check("s6_rst_we", {regWriteEnable_WB1, regWriteEnable_WB2}, 2'b00);
    check("s6_rst_wbdata", writeData_WB1 | writeData_WB2, 128'h0);
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      tick();
      check("s6_no_wb", {regWriteEnable_WB1, regWriteEnable_WB2}, 2'b00);
      check("s6_inflight", inFlight, 5'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spu_writeback_forward_pipe.md
# spu_writeback_forward_pipe

Dual-pipe result pipeline that sits directly downstream of the even and odd execution units and upstream of the register fetch stage's write ports. It holds in-flight 128-bit results for a fixed number of cycles, supplies forwarded operands for all six source-register reads of the two instructions in register fetch, and drives the two writeback ports (`writeData_WB1/2`, `readRegisterRT_WB1/2`, `regWriteEnable_WB1/2`) that update the 128x128 register file.

## Interface
- `DEPTH`, 6: stages per pipe; valid range 2..8.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `resValid_EX1`, `resValid_EX2` in 1: result present from pipe 1 (even) / pipe 2 (odd).
- `resRT_EX1`, `resRT_EX2` in 7: destination register.
- `resData_EX1`, `resData_EX2` in 128: result value.
- `stall` in 1: freeze the whole pipe.
- `flush` in 1: kill younger in-flight results.
- `readRegisterRA_REG1`, `readRegisterRA_REG2`, `readRegisterRB_REG1`, `readRegisterRB_REG2`, `readRegisterRC_REG1`, `readRegisterRC_REG2` in 7 each: source addresses being read in register fetch.
- `fwdHit[5:0]` out 6: bit order RA1, RA2, RB1, RB2, RC1, RC2; 1 = forwarded value valid.
- `fwdData0`..`fwdData5` out 128 each: forwarded values, same order.
- `readRegisterRT_WB1`, `readRegisterRT_WB2` out 7: writeback destinations.
- `writeData_WB1`, `writeData_WB2` out 128: writeback data.
- `regWriteEnable_WB1`, `regWriteEnable_WB2` out 1: writeback enables.
- `inFlight` out 5: count of valid entries across both pipes, all stages.

## Operation
- Each pipe has stages 0..DEPTH-1, each holding {valid, rt[6:0], data[127:0]}.
- Normal cycle (`stall`=0, `flush`=0): stage k+1 <= stage k; stage 0 <= {resValid, resRT, resData} of that pipe.
- Writeback: WBn outputs are driven from stage DEPTH-1 of pipe n; enable = stage valid AND NOT `stall`.
- Same-destination writeback: if both last stages are valid with equal rt, `regWriteEnable_WB1` is forced to 0 (pipe 2 is later in program order).
- `stall`=1: all stages hold; EX inputs are ignored (the producer holds them); both WB enables are 0; forwarding stays active.
- `flush`=1: valid bits of stages 0..DEPTH-2 in both pipes are cleared and EX inputs are dropped; stage DEPTH-1 contents shift out and retire normally. `flush` has priority over `stall`.
- Forwarding, per read address: search registered stages only (not current EX inputs), youngest stage first (stage 0 .. DEPTH-1); within one stage pipe 2 beats pipe 1. The first valid match sets the hit bit and data. No match: hit=0, data=0.
- Register 0 is an ordinary register; no special casing.
- `inFlight` = popcount of all valid bits, registered; maximum value 2*DEPTH (16 for DEPTH=8, fits in 5 bits).

## Timing
- Reset (asynchronous assert, synchronous release): all valid bits 0, rt and data 0; `fwdHit`=0, `fwdData*`=0, all WB outputs 0, `inFlight`=0.
- A result sampled at edge E sits in stage k from edge E+k. It is forwardable from edge E until it leaves stage DEPTH-1. WB is asserted in the cycle after edge E+DEPTH-1, so an unstalled result takes DEPTH cycles from EX to register write.
- Forward and WB outputs are combinational from stage registers. Address-to-`fwdHit` is a purely combinational path.
- Each stall cycle adds 1 to the latency of every entry. WB is never asserted twice for the same entry.
- Reset asserted mid-operation discards all entries immediately; no writeback occurs.

## Configuration
- `SPU_FWD_EN` defined: forwarding network as specified.
- `SPU_FWD_EN` undefined: no comparators are built. `fwdHit` ties to 0 and `fwdData*` to 0; the pipe, writeback, stall, flush and `inFlight` behave identically.

## Test plan
- Pipe 1 issues rt=5, data=0x1234 with DEPTH=6 and no stall -> `regWriteEnable_WB1`=1, `readRegisterRT_WB1`=5, `writeData_WB1`=0x1234 exactly 6 cycles after the issue edge. `inFlight` is 1 during that window, then 0.
- Pipe 1 issues rt=10 data=A at cycle 0 and rt=10 data=B at cycle 1; RA1=10 -> `fwdHit[0]`=1 with A after edge 0, then B from edge 1 onward (youngest wins).
- Both pipes issue rt=7 in the same cycle (data 0x11 on pipe 1, 0x22 on pipe 2) -> forward returns 0x22; at writeback only WB2 is enabled, with 0x22.
- Entry in stage 3 plus `stall` held 2 cycles -> WB enables 0 during the stall, and writeback is delayed exactly 2 cycles, occurring once.
- Entries in stages 0, 2 and DEPTH-1 with `flush`=1 and a new EX result present -> only the DEPTH-1 entry writes back. The new result is dropped and `inFlight` returns to 0.
- `reset_n` pulsed low with 4 entries in flight -> all outputs are 0 immediately; no WB after release. With `SPU_FWD_EN` undefined, the first scenario still passes and `fwdHit` stays 0.
